// File: rtl/cv32e40p_pkg.sv
// Shared types, widths and helpers for the writeback-arbiter slice.
// Imported by the interface, the arbiter top and its sub-modules.
package cv32e40p_pkg;

  localparam int REG_ADDR_W     = 6;
  localparam int WB_DATA_W      = 32;
  localparam int STARVE_CNT_W   = 4;
  localparam int CONFLICT_CNT_W = 16;

  typedef enum logic {
    PRIO_LSU = 1'b0,
    PRIO_ALU = 1'b1
  } wb_prio_e;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [WB_DATA_W-1:0]  wb_data_t;

  // x0 is hard-wired to zero, so it can never participate in a hazard.
  function automatic logic addr_hit(input reg_addr_t raddr,
                                    input reg_addr_t waddr,
                                    input logic      valid);
    return valid && (raddr != '0) && (raddr == waddr);
  endfunction

endpackage

// File: rtl/cv32e40p_wb_arbiter_if.sv
// Bundle of writeback requests, the shared register-file write port and the
// ID-stage hazard lookup; slave is the arbiter side, master the requester side.
interface cv32e40p_wb_arbiter_if;
  import cv32e40p_pkg::*;

  logic                      alu_req_i;
  reg_addr_t                 alu_waddr_i;
  wb_data_t                  alu_wdata_i;
  logic                      alu_gnt_o;

  logic                      lsu_req_i;
  reg_addr_t                 lsu_waddr_i;
  wb_data_t                  lsu_wdata_i;
  logic                      lsu_gnt_o;

  logic                      flush_i;

  logic                      regfile_we_o;
  reg_addr_t                 regfile_waddr_o;
  wb_data_t                  regfile_wdata_o;

  reg_addr_t                 raddr_a_i;
  reg_addr_t                 raddr_b_i;
  logic                      hazard_o;

  logic [CONFLICT_CNT_W-1:0] conflict_cnt_o;

  modport master (
    output alu_req_i, alu_waddr_i, alu_wdata_i,
    output lsu_req_i, lsu_waddr_i, lsu_wdata_i,
    output flush_i, raddr_a_i, raddr_b_i,
    input  alu_gnt_o, lsu_gnt_o,
    input  regfile_we_o, regfile_waddr_o, regfile_wdata_o,
    input  hazard_o, conflict_cnt_o
  );

  modport slave (
    input  alu_req_i, alu_waddr_i, alu_wdata_i,
    input  lsu_req_i, lsu_waddr_i, lsu_wdata_i,
    input  flush_i, raddr_a_i, raddr_b_i,
    output alu_gnt_o, lsu_gnt_o,
    output regfile_we_o, regfile_waddr_o, regfile_wdata_o,
    output hazard_o, conflict_cnt_o
  );

endinterface

// File: rtl/cv32e40p_sat_counter.sv
// Width-parameterized up-counter that sticks at all-ones instead of wrapping.
module cv32e40p_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (inc && (count_reg != '1)) begin
      count_next = count_reg + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/cv32e40p_wb_arbiter.sv
// Two-requester writeback arbiter (ALU vs LSU) onto one register-file write port,
// LSU-first with an ALU anti-starvation escalation, plus ID-stage hazard detection.
module cv32e40p_wb_arbiter
  import cv32e40p_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cv32e40p_wb_arbiter_if.slave  bus
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIMIT_C = STARVE_CNT_W'(STARVE_LIMIT);

  wb_prio_e                state_reg;
  wb_prio_e                state_next;
  logic [STARVE_CNT_W-1:0] starve_reg;
  logic [STARVE_CNT_W-1:0] starve_next;

  logic                    we_reg;
  logic                    we_next;
  reg_addr_t               waddr_reg;
  reg_addr_t               waddr_next;
  wb_data_t                wdata_reg;
  wb_data_t                wdata_next;

  logic                    alu_live;
  logic                    alu_gnt;
  logic                    lsu_gnt;

  // A flushed ALU request is invisible to arbitration and hazard tracking.
  assign alu_live = bus.alu_req_i && !bus.flush_i;

  always_comb begin
    alu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    if (rst_n) begin
      if (state_reg == PRIO_ALU) begin
        alu_gnt = alu_live;
        lsu_gnt = bus.lsu_req_i && !alu_live;
      end else begin
        lsu_gnt = bus.lsu_req_i;
        alu_gnt = alu_live && !bus.lsu_req_i;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    starve_next = starve_reg;

    if (alu_gnt || !bus.alu_req_i || bus.flush_i) begin
      starve_next = '0;
    end else if (starve_reg != '1) begin
      starve_next = starve_reg + STARVE_CNT_W'(1);
    end

    case (state_reg)
      PRIO_LSU: begin
        if (starve_reg == STARVE_LIMIT_C) begin
          state_next = PRIO_ALU;
        end
      end
      PRIO_ALU: begin
        if (alu_gnt || bus.flush_i) begin
          state_next = PRIO_LSU;
        end
      end
      default: state_next = PRIO_LSU;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= PRIO_LSU;
      starve_reg <= '0;
    end else begin
      state_reg  <= state_next;
      starve_reg <= starve_next;
    end
  end

  // Writes to x0 are consumed like any other grant but never enable the port.
  always_comb begin
    we_next    = 1'b0;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;
    if (alu_gnt) begin
      we_next    = (bus.alu_waddr_i != '0);
      waddr_next = bus.alu_waddr_i;
      wdata_next = bus.alu_wdata_i;
    end else if (lsu_gnt) begin
      we_next    = (bus.lsu_waddr_i != '0);
      waddr_next = bus.lsu_waddr_i;
      wdata_next = bus.lsu_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg    <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
    end else begin
      we_reg    <= we_next;
      waddr_reg <= waddr_next;
      wdata_reg <= wdata_next;
    end
  end

  reg_addr_t raddr [2];
  logic [1:0] hit;

  assign raddr[0] = bus.raddr_a_i;
  assign raddr[1] = bus.raddr_b_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_hazard
      assign hit[gi] = addr_hit(raddr[gi], bus.alu_waddr_i, alu_live && !alu_gnt)
                    || addr_hit(raddr[gi], bus.lsu_waddr_i, bus.lsu_req_i && !lsu_gnt)
                    || addr_hit(raddr[gi], waddr_reg, we_reg);
    end
  endgenerate

  logic [CONFLICT_CNT_W-1:0] conflict_cnt;

  cv32e40p_sat_counter #(
    .WIDTH (CONFLICT_CNT_W)
  ) u_conflict_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.alu_req_i && bus.lsu_req_i),
    .count (conflict_cnt)
  );

  assign bus.alu_gnt_o       = alu_gnt;
  assign bus.lsu_gnt_o       = lsu_gnt;
  assign bus.regfile_we_o    = we_reg;
  assign bus.regfile_waddr_o = waddr_reg;
  assign bus.regfile_wdata_o = wdata_reg;
  assign bus.hazard_o        = |hit;
  assign bus.conflict_cnt_o  = conflict_cnt;

endmodule

// File: tb/tb_cv32e40p_wb_arbiter.sv
// Bench for cv32e40p_wb_arbiter: directed scenarios, random traffic and
// counter saturation, all checked against a cycle-level reference model.
module tb_cv32e40p_wb_arbiter;
  import cv32e40p_pkg::*;

  localparam int LIMIT = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cv32e40p_wb_arbiter_if bus ();

  cv32e40p_wb_arbiter #(
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: who goes first, how long the ALU has waited, what the
  // register-file port shows, and how many both-requesting cycles were seen.
  bit          m_alu_first;
  int          m_denied;
  bit          m_we;
  logic [5:0]  m_waddr;
  logic [31:0] m_wdata;
  int          m_conflicts;
  bit          e_ag, e_lg;
  logic        obs_ag, obs_lg, obs_hz;
  bit          log_en = 1'b1;

  task automatic model_reset();
    m_alu_first = 1'b0;
    m_denied    = 0;
    m_we        = 1'b0;
    m_waddr     = '0;
    m_wdata     = '0;
    m_conflicts = 0;
  endtask

  task automatic step(input bit ar, input logic [5:0] aa, input logic [31:0] ad,
                      input bit lr, input logic [5:0] la, input logic [31:0] ld,
                      input bit fl, input logic [5:0] ra, input logic [5:0] rb);
    bit         live;
    bit         hz;
    logic [5:0] r;
    bus.alu_req_i   = ar;
    bus.alu_waddr_i = aa;
    bus.alu_wdata_i = ad;
    bus.lsu_req_i   = lr;
    bus.lsu_waddr_i = la;
    bus.lsu_wdata_i = ld;
    bus.flush_i     = fl;
    bus.raddr_a_i   = ra;
    bus.raddr_b_i   = rb;
    @(negedge clk);
    live = ar && !fl;
    if (m_alu_first) begin
      e_ag = live;
      e_lg = lr && !live;
    end else begin
      e_lg = lr;
      e_ag = live && !lr;
    end
    hz = 1'b0;
    for (int p = 0; p < 2; p++) begin
      r = (p == 0) ? ra : rb;
      if (r != 6'd0) begin
        if (live && !e_ag && r == aa) hz = 1'b1;
        if (lr && !e_lg && r == la)   hz = 1'b1;
        if (m_we && r == m_waddr)     hz = 1'b1;
      end
    end
    obs_ag = bus.alu_gnt_o;
    obs_lg = bus.lsu_gnt_o;
    obs_hz = bus.hazard_o;
    check_val("alu_gnt", 32'(obs_ag), 32'(e_ag));
    check_val("lsu_gnt", 32'(obs_lg), 32'(e_lg));
    check_val("hazard", 32'(obs_hz), 32'(hz));
    check_val("rf_we", 32'(bus.regfile_we_o), 32'(m_we));
    check_val("rf_waddr", 32'(bus.regfile_waddr_o), 32'(m_waddr));
    check_val("rf_wdata", bus.regfile_wdata_o, m_wdata);
    check_val("conflict_cnt", 32'(bus.conflict_cnt_o), 32'(m_conflicts));
    @(posedge clk);
    if (m_alu_first) begin
      if (e_ag || fl) m_alu_first = 1'b0;
    end else if (m_denied == LIMIT) begin
      m_alu_first = 1'b1;
    end
    if (e_ag || !ar || fl) m_denied = 0;
    else m_denied++;
    if (e_ag || e_lg) begin
      m_waddr = e_ag ? aa : la;
      m_wdata = e_ag ? ad : ld;
      m_we    = (m_waddr != 6'd0);
      if (log_en)
        $display("txn t=%0t %s x%0d <= %08h%s", $time, e_ag ? "ALU" : "LSU",
                 m_waddr, m_wdata, m_we ? "" : " (x0, dropped)");
    end else begin
      m_we = 1'b0;
    end
    if (ar && lr && m_conflicts < 65535) m_conflicts++;
    #1;
  endtask

  bit          ap, lp, fl;
  logic [5:0]  apa, lpa, ra, rb;
  logic [31:0] apd, lpd;

  initial begin
    bus.alu_req_i = 1'b0; bus.alu_waddr_i = '0; bus.alu_wdata_i = '0;
    bus.lsu_req_i = 1'b0; bus.lsu_waddr_i = '0; bus.lsu_wdata_i = '0;
    bus.flush_i   = 1'b0; bus.raddr_a_i   = '0; bus.raddr_b_i   = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_val("reset_we", 32'(bus.regfile_we_o), 32'd0);
    check_val("reset_waddr", 32'(bus.regfile_waddr_o), 32'd0);
    check_val("reset_wdata", bus.regfile_wdata_o, 32'd0);
    check_val("reset_conflict", 32'(bus.conflict_cnt_o), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Both request: LSU wins, then its write appears one cycle later.
    step(1, 6'd5, 32'h11, 1, 6'd6, 32'h22, 0, 6'd0, 6'd0);
    check_val("lsu_prio_lsu_gnt", 32'(obs_lg), 32'd1);
    check_val("lsu_prio_alu_gnt", 32'(obs_ag), 32'd0);
    check_val("lsu_prio_we", 32'(bus.regfile_we_o), 32'd1);
    check_val("lsu_prio_waddr", 32'(bus.regfile_waddr_o), 32'd6);
    check_val("lsu_prio_wdata", bus.regfile_wdata_o, 32'h22);
    step(1, 6'd5, 32'h11, 0, 6'd0, 32'h0, 0, 6'd0, 6'd0);
    check_val("alu_after_lsu_gnt", 32'(obs_ag), 32'd1);
    step(0, 6'd0, 32'h0, 0, 6'd0, 32'h0, 0, 6'd0, 6'd0);

    // Starvation: ALU held against continuous LSU traffic wins on cycle 5.
    for (int k = 1; k <= 5; k++) begin
      step(1, 6'd9, 32'h99, 1, 6'd7, 32'h70 + 32'(k), 0,
           (k == 5) ? 6'd9 : 6'd0, (k == 5) ? 6'd7 : 6'd0);
      check_val($sformatf("starve_alu_gnt_c%0d", k), 32'(obs_ag), 32'(k == 5));
      check_val($sformatf("starve_lsu_gnt_c%0d", k), 32'(obs_lg), 32'(k != 5));
    end
    check_val("haz_req_cycle", 32'(obs_hz), 32'd1);
    check_val("starve_waddr", 32'(bus.regfile_waddr_o), 32'd9);
    check_val("starve_wdata", bus.regfile_wdata_o, 32'h99);
    step(1, 6'd10, 32'haa, 1, 6'd7, 32'h75, 0, 6'd9, 6'd7);
    check_val("prio_restored_lsu", 32'(obs_lg), 32'd1);
    check_val("prio_restored_alu", 32'(obs_ag), 32'd0);
    check_val("haz_next_cycle", 32'(obs_hz), 32'd1);
    step(1, 6'd10, 32'haa, 0, 6'd0, 32'h0, 0, 6'd0, 6'd0);
    check_val("haz_raddr0", 32'(obs_hz), 32'd0);

    // ALU write to x0 is granted but never enables the port.
    step(1, 6'd0, 32'hdead, 0, 6'd0, 32'h0, 0, 6'd0, 6'd0);
    check_val("x0_alu_gnt", 32'(obs_ag), 32'd1);
    check_val("x0_we", 32'(bus.regfile_we_o), 32'd0);

    // Flush while the ALU alone requests after one denied cycle.
    step(1, 6'd3, 32'h33, 1, 6'd4, 32'h44, 0, 6'd0, 6'd0);
    step(1, 6'd3, 32'h33, 0, 6'd0, 32'h0, 1, 6'd3, 6'd0);
    check_val("flush_alu_gnt", 32'(obs_ag), 32'd0);
    check_val("flush_haz", 32'(obs_hz), 32'd0);
    check_val("flush_starve", 32'(dut.starve_reg), 32'd0);
    check_val("flush_we", 32'(bus.regfile_we_o), 32'd0);

    // Random traffic; requesters hold their request until granted or flushed.
    ap = 0; lp = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!ap && $urandom_range(0, 3) != 0) begin
        ap = 1; apa = 6'($urandom_range(0, 7)); apd = $urandom;
      end
      if (!lp && $urandom_range(0, 3) != 0) begin
        lp = 1; lpa = 6'($urandom_range(0, 7)); lpd = $urandom;
      end
      fl = ($urandom_range(0, 7) == 0);
      ra = 6'($urandom_range(0, 7));
      rb = 6'($urandom_range(0, 7));
      step(ap, apa, apd, lp, lpa, lpd, fl, ra, rb);
      if (e_ag || fl) ap = 0;
      if (e_lg) lp = 0;
    end

    // Asynchronous reset in the middle of a both-requesting cycle.
    bus.alu_req_i = 1'b1; bus.alu_waddr_i = 6'd12; bus.alu_wdata_i = 32'h1234;
    bus.lsu_req_i = 1'b1; bus.lsu_waddr_i = 6'd13; bus.lsu_wdata_i = 32'h5678;
    bus.flush_i   = 1'b0;
    @(posedge clk);
    #1;
    check_val("pre_rst_conflict_nonzero", 32'(bus.conflict_cnt_o != '0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_val("rst_alu_gnt", 32'(bus.alu_gnt_o), 32'd0);
    check_val("rst_lsu_gnt", 32'(bus.lsu_gnt_o), 32'd0);
    check_val("rst_we", 32'(bus.regfile_we_o), 32'd0);
    check_val("rst_waddr", 32'(bus.regfile_waddr_o), 32'd0);
    check_val("rst_wdata", bus.regfile_wdata_o, 32'd0);
    check_val("rst_conflict", 32'(bus.conflict_cnt_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_hold_alu_gnt", 32'(bus.alu_gnt_o), 32'd0);
    check_val("rst_hold_lsu_gnt", 32'(bus.lsu_gnt_o), 32'd0);
    check_val("rst_hold_conflict", 32'(bus.conflict_cnt_o), 32'd0);
    rst_n = 1'b1;
    step(1, 6'd12, 32'h1234, 1, 6'd13, 32'h5678, 0, 6'd0, 6'd0);
    check_val("first_gnt_after_rst", 32'(obs_lg), 32'd1);

    // Saturation of the conflict counter.
    log_en = 1'b0;
    for (int i = 0; i < 65540; i++) begin
      step(1, 6'd12, 32'h1234, 1, 6'd13, 32'h5678, 0, 6'd0, 6'd0);
    end
    check_val("conflict_saturated", 32'(bus.conflict_cnt_o), 32'h0000ffff);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cv32e40p_wb_arbiter.md
CV32E40P_WB_ARBITER -- requirements
Module: cv32e40p_wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: consecutive ALU-denied cycles after which the ALU takes priority; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 alu_req_i  input  1  ALU writeback request valid.
REQ-005 alu_waddr_i  input  6  ALU destination register address.
REQ-006 alu_wdata_i  input  32  ALU writeback data.
REQ-007 alu_gnt_o  output  1  ALU request accepted this cycle.
REQ-008 lsu_req_i  input  1  LSU writeback request valid.
REQ-009 lsu_waddr_i  input  6  LSU destination register address.
REQ-010 lsu_wdata_i  input  32  LSU writeback data.
REQ-011 lsu_gnt_o  output  1  LSU request accepted this cycle.
REQ-012 flush_i  input  1  squash the pending ALU request.
REQ-013 regfile_we_o  output  1  registered write enable to the shared register-file port.
REQ-014 regfile_waddr_o  output  6  registered write address.
REQ-015 regfile_wdata_o  output  32  registered write data.
REQ-016 raddr_a_i, raddr_b_i  input  6 each  ID-stage read addresses for hazard check.
REQ-017 hazard_o  output  1  a read address matches an in-flight or pending write.
REQ-018 conflict_cnt_o  output  16  saturating count of cycles with both requests asserted.

Function
REQ-019 Grants are combinational in the request cycle; at most one grant is high per cycle.
REQ-020 A requester holds req, waddr and wdata stable until granted; the arbiter relies on this.
REQ-021 State PRIO_LSU (reset state): if lsu_req_i, grant LSU; otherwise grant ALU if alu_req_i.
REQ-022 State PRIO_ALU: if alu_req_i, grant ALU; otherwise grant LSU if lsu_req_i.
REQ-023 Starvation counter: 4 bits; increments when alu_req_i is high and alu_gnt_o is low; clears on ALU grant, when alu_req_i is low, or on flush_i.
REQ-024 Transition PRIO_LSU to PRIO_ALU when the counter equals STARVE_LIMIT.
REQ-025 Transition PRIO_ALU to PRIO_LSU on the cycle after any ALU grant or on flush_i.
REQ-026 flush_i forces alu_gnt_o low in the same cycle; LSU arbitration proceeds as though alu_req_i were low.
REQ-027 Granted write registered: next cycle regfile_we_o=1 with the winner's waddr/wdata; otherwise regfile_we_o=0 and addr/data hold previous values.
REQ-028 Write latency is exactly 1 cycle from grant to regfile_we_o.
REQ-029 A granted write with waddr=0 is consumed but regfile_we_o stays 0.
REQ-030 hazard_o=1 when a nonzero raddr equals any of:
  - the waddr of an ungranted, unflushed request;
  - regfile_waddr_o while regfile_we_o=1.
  Evaluation is combinational.
REQ-031 Equal waddr from both requesters: only the winner is granted; the loser writes in a later cycle, so the last write wins in grant order.
REQ-032 conflict_cnt_o increments when alu_req_i and lsu_req_i are both high, including flushed cycles; it saturates at 16'hFFFF.

Reset
REQ-033 On rst_n low, asynchronously:
  - state is PRIO_LSU and the counter is 0;
  - regfile_we_o, regfile_waddr_o, regfile_wdata_o and conflict_cnt_o are 0.
REQ-034 During reset, grants are 0 regardless of requests; a request in flight at reset assertion is dropped.
REQ-035 First grant possible in the first cycle after rst_n deasserts.

Structure
REQ-036 The state enum (PRIO_LSU, PRIO_ALU) and the register-address width constant reside in cv32e40p_pkg.
REQ-037 The 16-bit saturating counter is one sub-module, cv32e40p_sat_counter, width-parameterized.

Verification
REQ-038 LSU-priority scenario:
  - stimulus: both requesters, ALU x5=0x11, LSU x6=0x22;
  - response: lsu_gnt_o=1 and alu_gnt_o=0 in the same cycle, then next cycle we=1, waddr=6, wdata=0x22.
REQ-039 Starvation scenario:
  - stimulus: STARVE_LIMIT=3, LSU requests continuously, ALU holds a request;
  - response: ALU granted on the 5th cycle (counter reaches 3 after 3 denied cycles, PRIO_ALU active on the 4th denied-cycle edge), then LSU priority is restored the following cycle.
REQ-040 x0 scenario:
  - stimulus: ALU-only write to x0;
  - response: alu_gnt_o=1 and regfile_we_o stays 0.
REQ-041 Hazard scenario:
  - stimulus: LSU holding x7, ALU granted x9, raddr_a_i=9, raddr_b_i=7;
  - response: hazard_o=1 in the request cycle and the next cycle; with raddr=0, hazard_o=0.
REQ-042 Flush scenario:
  - stimulus: flush_i pulsed while only ALU requests;
  - response: alu_gnt_o=0, counter=0, no write next cycle.
REQ-043 Reset and saturation scenario:
  - stimulus: rst_n asserted mid-stream with both requesting;
  - response: outputs and conflict_cnt_o are 0 immediately;
  - saturation check: force 65540 conflict cycles, and conflict_cnt_o holds 0xFFFF.
